// File: rtl/flag_pkg.sv
// Shared types for the flag/branch path: NZCV layout, ARM condition codes and branch kinds.
package flag_pkg;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    typedef enum logic [3:0] {
        EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
        MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
        HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
        GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
    } cond_e;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        BCOND = 2'd1,
        CBZ   = 2'd2,
        CBNZ  = 2'd3
    } br_kind_e;

endpackage

// File: rtl/flag_branch_unit_cond_eval.sv
// Combinational ARM condition-code evaluator; also intended for a future conditional-select unit.
module cond_eval
    import flag_pkg::*;
(
    input  nzcv_t flags,
    input  cond_e cond,
    output logic  taken
);

    always_comb begin
        taken = 1'b1;
        case (cond)
            EQ: taken = flags.z;
            NE: taken = !flags.z;
            CS: taken = flags.c;
            CC: taken = !flags.c;
            MI: taken = flags.n;
            PL: taken = !flags.n;
            VS: taken = flags.v;
            VC: taken = !flags.v;
            HI: taken = flags.c & !flags.z;
            LS: taken = !flags.c | flags.z;
            GE: taken = (flags.n == flags.v);
            LT: taken = (flags.n != flags.v);
            GT: taken = !flags.z & (flags.n == flags.v);
            LE: taken = flags.z | (flags.n != flags.v);
            AL: taken = 1'b1;
            NV: taken = 1'b1;
            default: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural NZCV register plus B.cond/CBZ/CBNZ resolution.
// Define FLAG_FWD_EN to bypass EX flags into evaluation instead of stalling B.cond.
module flag_branch_unit
    import flag_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ex_valid,
    input  logic       ex_set_flags,
    input  logic       ex_negative,
    input  logic       ex_zero,
    input  logic       ex_overflow,
    input  logic       ex_carry_out,
    input  logic       flush,
    input  logic       br_valid,
    input  logic [1:0] br_kind,
    input  logic [3:0] br_cond,
    input  logic       br_reg_zero,
    output logic       br_stall,
    output logic       res_valid,
    output logic       res_taken,
    output logic [3:0] nzcv
);

    nzcv_t    nzcv_q;
    nzcv_t    ex_flags;
    nzcv_t    eff_flags;
    br_kind_e kind;
    logic     flag_write;
    logic     cond_taken;
    logic     resolve;
    logic     taken;

    assign ex_flags   = '{n: ex_negative, z: ex_zero, c: ex_carry_out, v: ex_overflow};
    assign flag_write = ex_valid & ex_set_flags & !flush;
    assign kind       = br_kind_e'(br_kind);
    assign nzcv       = nzcv_q;

`ifdef FLAG_FWD_EN
    assign eff_flags = flag_write ? ex_flags : nzcv_q;
    assign br_stall  = 1'b0;
`else
    // B.cond waits one cycle for the pending flag write to land in nzcv_q.
    assign eff_flags = nzcv_q;
    assign br_stall  = reset_n & br_valid & (kind == BCOND) & flag_write;
`endif

    cond_eval u_cond_eval (
        .flags (eff_flags),
        .cond  (cond_e'(br_cond)),
        .taken (cond_taken)
    );

    always_comb begin
        taken = 1'b0;
        case (kind)
            BCOND:   taken = cond_taken;
            CBZ:     taken = br_reg_zero;
            CBNZ:    taken = !br_reg_zero;
            default: taken = 1'b0;
        endcase
    end

    assign resolve = br_valid & (kind != NONE) & !br_stall & !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nzcv_q <= '0;
        end else if (flag_write) begin
            nzcv_q <= ex_flags;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_valid <= 1'b0;
            res_taken <= 1'b0;
        end else begin
            res_valid <= resolve;
            res_taken <= resolve & taken;
        end
    end

endmodule

// File: doc/flag_branch_unit.md
# flag_branch_unit

Flag consumer at the far end of the ALU status interface. It holds the architectural NZCV register, which is written by flag-setting instructions leaving EX. It resolves B.cond, CBZ and CBNZ requests from ID against those flags, optionally forwarding flags from EX in the same cycle. It sits between the ALU flag outputs (negative, zero, overflow, carry_out) and the fetch/PC-select logic.

## Interface
Parameters:
- None. All widths are fixed: 4-bit cond, 2-bit branch kind, 4-bit NZCV.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- ex_valid  input  1  EX-stage instruction valid.
- ex_set_flags  input  1  EX instruction writes flags (ADDS, SUBS, ANDS, ...).
- ex_negative, ex_zero, ex_overflow, ex_carry_out  input  1 each  ALU flag outputs for the EX instruction.
- flush  input  1  squashes the EX flag write and the ID branch in the current cycle.
- br_valid  input  1  ID-stage branch request present.
- br_kind  input  2  0 = none, 1 = B.cond, 2 = CBZ, 3 = CBNZ.
- br_cond  input  4  ARM condition code; used only for B.cond.
- br_reg_zero  input  1  Rt == 0, used for CBZ and CBNZ.
- br_stall  output  1  combinational; ID must hold the branch this cycle.
- res_valid  output  1  registered; a branch was resolved last cycle.
- res_taken  output  1  registered; the resolved branch is taken.
- nzcv  output  4  registered architectural flags {N,Z,C,V}.

## Operation
- Flag write: on a clock edge with ex_valid & ex_set_flags & !flush, nzcv <= {ex_negative, ex_zero, ex_carry_out, ex_overflow}. Otherwise nzcv holds.
- Effective flags for evaluation:
  - Equal to the EX flags when forwarding is enabled and ex_valid & ex_set_flags & !flush.
  - Equal to nzcv in every other case.
- Condition decode follows ARM semantics:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL = 1; NV (4'hF) = 1.
- CBZ: taken = br_reg_zero. CBNZ: taken = !br_reg_zero. These never stall and never read the flags.
- Resolve condition: br_valid & br_kind != 0 & !br_stall & !flush. When it holds, the next edge sets res_valid = 1 and res_taken = evaluated result. Otherwise res_valid = 0 and res_taken = 0.
- br_kind = 0 with br_valid = 1 is treated as no request.
- flush has priority over everything else: no flag write, no resolution, and br_stall = 0.

## Timing
- Reset, asynchronous on reset_n low: nzcv = 4'b0000, res_valid = 0, res_taken = 0. br_stall is 0 while reset_n is low.
- Deasserting reset mid-operation discards any in-flight branch. A request presented in the first cycle after release resolves normally.
- Latency: the branch is presented in cycle t, and res_valid/res_taken appear in cycle t+1.
- Flag write latency: ex_set_flags in cycle t makes nzcv visible in cycle t+1.
- When a flag write and a B.cond occur in the same cycle, the branch sees the new flags if forwarding is enabled. Otherwise it stalls, as described under Configuration.
- Back-to-back branches in consecutive cycles are allowed. res_valid can be high every cycle.

## Configuration
- FLAG_FWD_EN defined: the EX flags are bypassed into evaluation, and br_stall is constantly 0.
- FLAG_FWD_EN undefined:
  - br_stall = br_valid & br_kind==1 & ex_valid & ex_set_flags & !flush.
  - The branch is held exactly one cycle. It then resolves against the updated nzcv in cycle t+1, with its result in t+2.
  - CBZ and CBNZ never stall.

## Structure
- flag_pkg package contains:
  - typedef nzcv_t: packed struct {n, z, c, v}.
  - enum cond_e: EQ=0 … NV=15.
  - enum br_kind_e: NONE, BCOND, CBZ, CBNZ.
- One sub-module, cond_eval: purely combinational (nzcv_t, cond_e) -> taken. It is reusable by a later conditional-select unit.
- flag_branch_unit contains:
  - the NZCV register
  - the forwarding mux
  - the stall logic
  - the result register

## Test plan
- Reset: hold reset_n = 0 with all inputs toggling -> nzcv = 0000, res_valid = 0. Then release and issue B.EQ -> res_valid = 1, res_taken = 0.
- SUBS producing Z=1, C=1 in cycle 5, then B.EQ in cycle 6 -> nzcv = 0110 in cycle 6, res_taken = 1 in cycle 7. B.HI in cycle 7 -> res_taken = 0 in cycle 8.
- Same-cycle SUBS (N=1, V=0) and B.LT:
  - With FLAG_FWD_EN: br_stall = 0, and res_taken = 1 next cycle.
  - Without it: br_stall = 1 for one cycle, then res_taken = 1 one cycle later.
- CBZ with br_reg_zero = 1, concurrent with a flag write -> no stall in either build, res_taken = 1. CBNZ with br_reg_zero = 1 -> res_taken = 0.
- flush asserted together with ex_set_flags (Z=1) and B.EQ, with starting nzcv = 0000 -> nzcv stays 0000, res_valid = 0, br_stall = 0.
- Exhaustive: all 16 cond codes × all 16 nzcv values -> res_taken matches the ARM truth table, with AL and NV always 1.
